// File: rtl/swipt_pkg.sv
// Shared constants and FSM state type for the SWIPT link transmitter.
package swipt_pkg;

  localparam logic [31:0] CLK_HZ     = 32'd100_000_000;
  localparam logic [31:0] F_MIN      = 32'd26_000;
  localparam logic [31:0] F_MAX      = 32'd56_000;
  localparam logic [31:0] F_DEFAULT  = 32'd41_000;
  localparam logic [31:0] HP_DEFAULT = CLK_HZ / (32'd2 * F_DEFAULT);

  typedef enum logic [1:0] {
    READY,
    DIVIDE,
    PENDING
  } link_state_t;

  function automatic logic [31:0] clamp_freq(input logic [31:0] f);
    if (f < F_MIN) return F_MIN;
    if (f > F_MAX) return F_MAX;
    return f;
  endfunction

endpackage

// File: rtl/seq_div32.sv
// Restoring radix-2 unsigned divider: one quotient bit per clock, 32 clocks per divide.
module seq_div32 (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] remainder_q;
  logic [31:0] quo_q;
  logic [31:0] den_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;

  // Bit 32 of the trial difference is the borrow: clear means the divisor fits.
  assign shifted  = {remainder_q, quo_q[31]};
  assign trial    = shifted - {1'b0, den_q};
  assign fits     = ~trial[32];
  assign quotient = quo_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      remainder_q <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder_q <= '0;
        quo_q       <= dividend;
        den_q       <= divisor;
        cnt_q       <= '0;
        busy_q      <= 1'b1;
      end else if (busy_q) begin
        remainder_q <= fits ? trial[31:0] : shifted[31:0];
        quo_q       <= {quo_q[30:0], fits};
        cnt_q       <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/swipt_link_tx.sv
// SWIPT transmit carrier: clamps a requested frequency, divides it down to a
// half-period count and retunes the square wave only at a link toggle.
module swipt_link_tx
  import swipt_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [31:0] freq_in,
  input  logic        freq_valid,
  output logic        freq_ready,
  output logic        link,
  output logic        link_edge,
  output logic [31:0] f_active,
  output logic        clamped
);

  link_state_t state_q, state_d;

  logic [31:0] f_req;
  logic [31:0] hp_staged;
  logic [31:0] half_period;
  logic [31:0] counter;
  logic        alive_q;
  logic        accept;
  logic        apply;
  logic        tick;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] f_clamped;
  logic [31:0] next_hp;

  assign f_clamped = clamp_freq(freq_in);
  assign tick      = swiptAlive && alive_q && (counter == 32'd0);
  assign next_hp   = apply ? hp_staged : half_period;

  seq_div32 u_div (
    .clk      (clk),
    .nrst     (nrst),
    .start    (accept),
    .dividend (CLK_HZ),
    .divisor  (f_clamped << 1),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  // A staged value waits for a toggle, unless the carrier is off, when nothing can glitch.
  always_comb begin
    state_d    = state_q;
    freq_ready = 1'b0;
    accept     = 1'b0;
    apply      = 1'b0;
    case (state_q)
      READY: begin
        freq_ready = 1'b1;
        if (freq_valid) begin
          accept  = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) state_d = PENDING;
      end
      PENDING: begin
        if (!swiptAlive || tick) begin
          apply   = 1'b1;
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      f_req       <= F_DEFAULT;
      hp_staged   <= HP_DEFAULT;
      half_period <= HP_DEFAULT;
      f_active    <= F_DEFAULT;
      clamped     <= 1'b0;
    end else begin
      clamped <= accept && ((freq_in < F_MIN) || (freq_in > F_MAX));
      if (accept) f_req <= f_clamped;
      if ((state_q == DIVIDE) && div_done) hp_staged <= div_quotient;
      if (apply) begin
        half_period <= hp_staged;
        f_active    <= f_req;
      end
    end
  end

  // Forced low on disable is silent; re-enable restarts a full half-period.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      counter   <= '0;
      link      <= 1'b0;
      link_edge <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      link_edge <= 1'b0;
      alive_q   <= swiptAlive;
      if (!swiptAlive) begin
        link    <= 1'b0;
        counter <= '0;
      end else if (!alive_q) begin
        counter <= half_period - 32'd1;
      end else if (counter == 32'd0) begin
        link      <= ~link;
        link_edge <= 1'b1;
        counter   <= next_hp - 32'd1;
      end else begin
        counter <= counter - 32'd1;
      end
    end
  end

endmodule
